apb_regbank_ws: RTL and testbench
=================================

Name: apb_regbank_ws

Overview:
Parametrised APB4 completer register bank, the successor to the single-width zero-wait peripheral. Width, depth, wait states, read-only and privileged register maps are all parameters. PSLVERR decode covers range, alignment, protection and read-only violations. A hardware-side update port lets the surrounding design write status registers and observe the register contents.

Parameters:
ADDR_WIDTH, 12, PADDR width in bits
DATA_WIDTH, 32, PWDATA/PRDATA width; must be 32 or 64; STRB_WIDTH = DATA_WIDTH/8
NUM_REGS, 16, number of registers; must be at most 2**(ADDR_WIDTH-log2(STRB_WIDTH))
READ_WS, 0, wait states inserted on reads (0..15)
WRITE_WS, 1, wait states inserted on writes (0..15)
RO_MASK, '0, NUM_REGS-bit mask; bit i=1 makes register i read-only from APB
PRIV_MASK, '0, NUM_REGS-bit mask; bit i=1 requires pprot[0]=1 for any access

Ports:
pclk  in  1  APB clock
presetn  in  1  asynchronous active-low reset
psel  in  1  completer select
penable  in  1  access phase
pwrite  in  1  1=write, 0=read
paddr  in  ADDR_WIDTH  byte address
pwdata  in  DATA_WIDTH  write data
pstrb  in  STRB_WIDTH  byte-lane write strobes (1=write lane)
pprot  in  3  protection attributes
prdata  out  DATA_WIDTH  read data
pready  out  1  transfer complete
pslverr  out  1  transfer error, valid only with pready
hw_we  in  1  hardware-side write enable
hw_idx  in  $clog2(NUM_REGS)  hardware-side register index
hw_wdata  in  DATA_WIDTH  hardware-side write data (full word)
reg_q  out  NUM_REGS*DATA_WIDTH  flattened register contents, register i at [i*DATA_WIDTH+:DATA_WIDTH]
proto_err  out  1  sticky; set on an aborted transfer, cleared only by reset

Behaviour:
- Reset (presetn low, asynchronous): all registers 0, FSM to IDLE, wait counter 0, proto_err 0. prdata, pready and pslverr are 0 while in reset.
- FSM has two states, IDLE and ACCESS.
  - IDLE: psel=1 and penable=0 (setup phase) captures paddr, pwrite, pprot and pstrb. The counter loads READ_WS or WRITE_WS and the FSM moves to ACCESS. psel=1 with penable=1 in IDLE is ignored and sets proto_err.
  - ACCESS: while the counter is nonzero, pready=0 and the counter decrements each cycle.
  - ACCESS with counter=0, psel=1 and penable=1: pready=1 combinationally in that cycle, the transfer commits, and the FSM returns to IDLE.
- Zero-wait transfers therefore take 2 cycles (setup + access); N wait states take 2+N cycles. Back-to-back transfers re-enter through IDLE on the next setup cycle.
- Abort: psel=0 or penable=0 in any ACCESS cycle returns the FSM to IDLE with no register update, pready=0, and proto_err set.
- Error decode uses captured values plus live paddr/pwrite at the commit cycle. pslverr=1 with pready when any of the following holds:
  - paddr low log2(STRB_WIDTH) bits are nonzero (misaligned)
  - word index >= NUM_REGS
  - PRIV_MASK[idx]=1 and pprot[0]=0
  - write to an index with RO_MASK[idx]=1
  - live paddr or pwrite differs from the setup-phase capture
- On an errored transfer, no register changes and prdata=0.
- Write commit: byte lane b of register idx updates from pwdata when pstrb[b]=1. pstrb=0 is a legal write that changes nothing and returns OK.
- Read: prdata = register contents during the pready cycle only; prdata is 0 in all other cycles. prdata is never driven to Z.
- hw_we writes the full word at hw_idx, RO registers included. An out-of-range hw_idx is ignored.
- Simultaneous APB commit and hw_we to the same index: the APB write wins for RW registers. RO registers never take APB writes, so no conflict arises there.
- reg_q reflects register state one cycle after either write.

Decomposition:
- apb_pkg holds:
  - apb_state_e (IDLE, ACCESS)
  - a function that returns the word index from paddr
  - the alignment-check function, parametrised on STRB_WIDTH
  - the maximum wait-state constant (15)
- One sub-module, apb_wait_timer: loadable 4-bit down-counter with a done flag, instantiated once.

Test Plan:
- Reset, then 32-bit write 0xDEADBEEF to 0x004 (WRITE_WS=1), then read 0x004 -> pready high on the 3rd write cycle, pslverr=0; read returns 0xDEADBEEF on its 2nd cycle (READ_WS=0).
- Write 0xAABBCCDD with pstrb=4'b0101 over reg 2 holding 0x11223344 -> reg 2 = 0x11BB33DD.
- Four error writes, each giving pslverr=1 and no update:
  - misaligned paddr=0x006
  - paddr=0x040 with NUM_REGS=16
  - RO_MASK[3]=1, write to 0x00C
  - PRIV_MASK[1]=1, access with pprot=3'b000
- Deassert psel in the 1st ACCESS wait cycle of a write -> no pready, register unchanged, proto_err=1 until the next reset.
- hw_we to reg 5 (0x12345678) in the same cycle as an APB commit writing 0xFFFFFFFF to reg 5 (RW) -> reg 5 = 0xFFFFFFFF. Repeat with reg 5 RO -> reg 5 = 0x12345678 and pslverr=1.
- Assert presetn low mid-wait (WRITE_WS=3, cycle 2) -> all outputs 0 immediately and the register keeps its reset value 0. The first transfer after reset completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and address helpers for the APB register bank with wait states.
package apb_pkg;

  typedef enum logic {IDLE, ACCESS} apb_state_e;

  localparam int unsigned APB_MAX_WS = 15;
  localparam int unsigned WS_W       = 4;

  // Byte address to word index for a 32-bit (4 lanes) or 64-bit (8 lanes) bus.
  function automatic logic [31:0] apb_word_idx(input logic [31:0] addr, input int strb_w);
    return (strb_w == 8) ? (addr >> 3) : (addr >> 2);
  endfunction

  function automatic logic apb_misaligned(input logic [31:0] addr, input int strb_w);
    return (strb_w == 8) ? (|addr[2:0]) : (|addr[1:0]);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Loadable 4-bit down-counter; o_done is high whenever the count is zero.
module apb_wait_timer
  import apb_pkg::*;
(
  input  logic            pclk,
  input  logic            presetn,
  input  logic            i_load,
  input  logic [WS_W-1:0] i_val,
  input  logic            i_dec,
  output logic            o_done
);

  logic [WS_W-1:0] r_cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/apb_regbank_ws.sv
// APB4 completer register bank with configurable wait states, RO/privileged maps,
// PSLVERR decode and a hardware-side full-word update port.
module apb_regbank_ws
  import apb_pkg::*;
#(
  parameter int                     ADDR_WIDTH = 12,
  parameter int                     DATA_WIDTH = 32,
  parameter int                     NUM_REGS   = 16,
  parameter int                     READ_WS    = 0,
  parameter int                     WRITE_WS   = 1,
  parameter logic [NUM_REGS-1:0]    RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]    PRIV_MASK  = '0,
  localparam int                    STRB_WIDTH = DATA_WIDTH / 8,
  localparam int                    IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                           pclk,
  input  logic                           presetn,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [STRB_WIDTH-1:0]          pstrb,
  input  logic [2:0]                     pprot,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  input  logic                           hw_we,
  input  logic [IDX_W-1:0]               hw_idx,
  input  logic [DATA_WIDTH-1:0]          hw_wdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic                           proto_err
);

  apb_state_e              r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic                    r_priv;
  logic [STRB_WIDTH-1:0]   r_strb;
  logic                    r_proto_err;
  logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0]   w_next [NUM_REGS];

  logic                    w_setup;
  logic                    w_active;
  logic                    w_cnt_done;
  logic [WS_W-1:0]         w_ws_val;
  logic                    w_commit;
  logic [31:0]             w_word;
  logic                    w_in_range;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_err;
  logic                    w_apb_we;
  logic                    w_unused;

  assign w_unused = ^pprot[2:1];
  assign w_setup  = (r_state == IDLE) && psel && !penable;
  assign w_active = psel && penable;
  assign w_ws_val = pwrite ? WS_W'(WRITE_WS) : WS_W'(READ_WS);

  apb_wait_timer u_timer (
    .pclk    (pclk),
    .presetn (presetn),
    .i_load  (w_setup),
    .i_val   (w_ws_val),
    .i_dec   (r_state == ACCESS),
    .o_done  (w_cnt_done)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= IDLE;
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_state <= ACCESS;
          end else if (w_active) begin
            r_proto_err <= 1'b1;
          end
        end
        ACCESS: begin
          if (!w_active) begin
            r_state     <= IDLE;
            r_proto_err <= 1'b1;
          end else if (w_cnt_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Setup-phase capture is data only; it is always rewritten before being used.
  always_ff @(posedge pclk) begin
    if (w_setup) begin
      r_addr  <= paddr;
      r_write <= pwrite;
      r_priv  <= pprot[0];
      r_strb  <= pstrb;
    end
  end

  assign w_commit   = (r_state == ACCESS) && w_cnt_done && w_active;
  assign w_word     = apb_word_idx(32'(r_addr), STRB_WIDTH);
  assign w_in_range = (w_word < 32'(NUM_REGS));
  assign w_idx      = w_word[IDX_W-1:0];

  always_comb begin
    w_err = apb_misaligned(32'(r_addr), STRB_WIDTH) || !w_in_range ||
            (paddr != r_addr) || (pwrite != r_write);
    if (w_in_range) begin
      if (PRIV_MASK[w_idx] && !r_priv) w_err = 1'b1;
      if (RO_MASK[w_idx] && r_write)   w_err = 1'b1;
    end
  end

  assign w_apb_we = w_commit && r_write && !w_err;
  assign pready   = w_commit;
  assign pslverr  = w_commit && w_err;
  assign prdata   = (w_commit && !r_write && !w_err) ? r_regs[w_idx] : '0;

  // Hardware update lands first so that APB byte lanes override it on a same-index collision.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_next[i] = r_regs[i];
      if (hw_we && (hw_idx == IDX_W'(i))) w_next[i] = hw_wdata;
      if (w_apb_we && (w_idx == IDX_W'(i))) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (r_strb[b]) w_next[i][b*8 +: 8] = pwdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= w_next[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_apb_regbank_ws.sv
// Bench for apb_regbank_ws: two configurations sharing one bus, checked against a word-array model.
module tb_apb_regbank_ws;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel_a, psel_b, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, hw_wdata;
  logic [3:0]  pstrb, hw_idx;
  logic [2:0]  pprot;
  logic        hw_we_a, hw_we_b;

  logic [31:0]  a_prdata, b_prdata;
  logic         a_pready, b_pready, a_pslverr, b_pslverr, a_perr, b_perr;
  logic [511:0] a_regq;
  logic [383:0] b_regq;

  logic [31:0] mA [16];
  logic [31:0] mB [12];
  int n_chk = 0;
  int n_fail = 0;

  localparam logic [15:0] A_RO = 16'h0008, A_PRIV = 16'h0002;

  always #5 pclk = ~pclk;

  apb_regbank_ws #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(16), .READ_WS(0), .WRITE_WS(1),
                   .RO_MASK(A_RO), .PRIV_MASK(A_PRIV)) dut_a (
    .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(a_prdata),
    .pready(a_pready), .pslverr(a_pslverr), .hw_we(hw_we_a), .hw_idx(hw_idx),
    .hw_wdata(hw_wdata), .reg_q(a_regq), .proto_err(a_perr));

  apb_regbank_ws #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(12), .READ_WS(2), .WRITE_WS(3),
                   .RO_MASK(12'h020), .PRIV_MASK(12'h000)) dut_b (
    .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(b_prdata),
    .pready(b_pready), .pslverr(b_pslverr), .hw_we(hw_we_b), .hw_idx(hw_idx),
    .hw_wdata(hw_wdata), .reg_q(b_regq), .proto_err(b_perr));

  // Full APB transfer; cyc counts setup as cycle 1. rd_leak flags nonzero prdata outside pready.
  task automatic apb_xfer(input bit b, input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input logic [2:0] pr, input bit hw_on,
                          output logic [31:0] rd, output logic err, output int cyc, output bit rd_leak);
    bit done = 0;
    @(posedge pclk); #1;
    if (b) psel_b = 1; else psel_a = 1;
    penable = 0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st; pprot = pr;
    cyc = 1; rd = '0; err = 1'b0; rd_leak = 0;
    @(posedge pclk); #1;
    penable = 1;
    if (b) hw_we_b = hw_on; else hw_we_a = hw_on;
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      cyc++;
      if (b ? b_pready : a_pready) begin
        done = 1; rd = b ? b_prdata : a_prdata; err = b ? b_pslverr : a_pslverr;
      end else if ((b ? b_prdata : a_prdata) !== 32'h0) rd_leak = 1;
      @(posedge pclk); #1;
      if (done) break;
    end
    psel_a = 0; psel_b = 0; penable = 0; hw_we_a = 0; hw_we_b = 0;
  endtask

  function automatic bit exp_err_a(bit wr, int addr, logic [2:0] pr);
    int idx = addr / 4;
    if ((addr % 4) != 0 || idx >= 16) return 1;
    if (A_PRIV[idx] && !pr[0]) return 1;
    if (wr && A_RO[idx]) return 1;
    return 0;
  endfunction

  task automatic test_reset();
    presetn = 0; psel_a = 0; psel_b = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    pstrb = '0; pprot = '0; hw_we_a = 0; hw_we_b = 0; hw_idx = '0; hw_wdata = '0;
    for (int i = 0; i < 16; i++) mA[i] = '0;
    for (int i = 0; i < 12; i++) mB[i] = '0;
    repeat (3) @(posedge pclk);
    #1;
    n_chk++; if ({a_pready, a_pslverr, b_pready, b_pslverr} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 0000", {a_pready, a_pslverr, b_pready, b_pslverr}); end
    n_chk++; if (a_prdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata got %h want 0", a_prdata); end
    n_chk++; if (a_regq !== '0 || b_regq !== '0) begin n_fail++; $display("FAIL reset_regq nonzero"); end
    n_chk++; if ({a_perr, b_perr} !== 2'b00) begin n_fail++; $display("FAIL reset_proto got %b want 00", {a_perr, b_perr}); end
    presetn = 1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err; int cyc; bit lk;
    apb_xfer(0, 1, 12'h004, 32'hDEADBEEF, 4'hF, 3'b001, 0, rd, err, cyc, lk);
    mA[1] = 32'hDEADBEEF;
    n_chk++; if (cyc !== 3 || err !== 1'b0) begin n_fail++; $display("FAIL wr_timing got cyc=%0d err=%b want 3/0", cyc, err); end
    apb_xfer(0, 0, 12'h004, 32'h0, 4'h0, 3'b001, 0, rd, err, cyc, lk);
    n_chk++; if (cyc !== 2 || err !== 1'b0) begin n_fail++; $display("FAIL rd_timing got cyc=%0d err=%b want 2/0", cyc, err); end
    n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got %h want deadbeef", rd); end
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic err; int cyc; bit lk;
    apb_xfer(0, 1, 12'h008, 32'h11223344, 4'hF, 3'b000, 0, rd, err, cyc, lk);
    apb_xfer(0, 1, 12'h008, 32'hAABBCCDD, 4'b0101, 3'b000, 0, rd, err, cyc, lk);
    mA[2] = 32'h11BB33DD;
    n_chk++; if (a_regq[2*32 +: 32] !== 32'h11BB33DD) begin n_fail++; $display("FAIL strobe got %h want 11bb33dd", a_regq[2*32 +: 32]); end
    apb_xfer(0, 1, 12'h008, 32'h99999999, 4'h0, 3'b000, 0, rd, err, cyc, lk);
    n_chk++; if (err !== 1'b0 || a_regq[2*32 +: 32] !== 32'h11BB33DD) begin n_fail++; $display("FAIL strobe_zero got err=%b reg=%h want 0/11bb33dd", err, a_regq[2*32 +: 32]); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int cyc; bit lk;
    logic [11:0] addrs [4] = '{12'h006, 12'h040, 12'h00C, 12'h004};
    logic        wrs   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 4; t++) begin
      apb_xfer(0, wrs[t], addrs[t], $urandom, 4'hF, 3'b000, 0, rd, err, cyc, lk);
      n_chk++; if (err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_case%0d got err=%b rd=%h want 1/0", t, err, rd); end
    end
    apb_xfer(0, 1, 12'h004, 32'h55555555, 4'hF, 3'b110, 0, rd, err, cyc, lk);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_priv_wr got %b want 1", err); end
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (a_regq[i*32 +: 32] !== mA[i]) begin n_fail++; $display("FAIL err_noupd reg%0d got %h want %h", i, a_regq[i*32 +: 32], mA[i]); end
    end
  endtask

  task automatic test_hw_conflict();
    logic [31:0] rd; logic err; int cyc; bit lk;
    hw_idx = 4'd5; hw_wdata = 32'h12345678;
    apb_xfer(0, 1, 12'h014, 32'hFFFFFFFF, 4'hF, 3'b000, 1, rd, err, cyc, lk);
    mA[5] = 32'hFFFFFFFF;
    n_chk++; if (err !== 1'b0 || a_regq[5*32 +: 32] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL hw_rw got err=%b reg=%h want 0/ffffffff", err, a_regq[5*32 +: 32]); end
    apb_xfer(1, 1, 12'h014, 32'hFFFFFFFF, 4'hF, 3'b000, 1, rd, err, cyc, lk);
    mB[5] = 32'h12345678;
    n_chk++; if (err !== 1'b1 || b_regq[5*32 +: 32] !== 32'h12345678) begin n_fail++; $display("FAIL hw_ro got err=%b reg=%h want 1/12345678", err, b_regq[5*32 +: 32]); end
    n_chk++; if (cyc !== 5) begin n_fail++; $display("FAIL b_wr_timing got %0d want 5", cyc); end
    apb_xfer(1, 0, 12'h014, 32'h0, 4'h0, 3'b000, 0, rd, err, cyc, lk);
    n_chk++; if (rd !== 32'h12345678 || cyc !== 4 || lk) begin n_fail++; $display("FAIL b_rd got %h cyc=%0d leak=%b want 12345678/4/0", rd, cyc, lk); end
    @(posedge pclk); #1; hw_idx = 4'd13; hw_wdata = 32'hCAFEF00D; hw_we_b = 1;
    @(posedge pclk); #1; hw_we_b = 0;
    for (int i = 0; i < 12; i++) begin
      n_chk++; if (b_regq[i*32 +: 32] !== mB[i]) begin n_fail++; $display("FAIL hw_oob reg%0d got %h want %h", i, b_regq[i*32 +: 32], mB[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd; logic err; int cyc; bit lk, wr, e; int addr; logic [3:0] st; logic [2:0] pr;
    for (int t = 0; t < 60; t++) begin
      wr = 1'($urandom); addr = $urandom_range(0, 71); wd = $urandom;
      st = 4'($urandom); pr = 3'($urandom);
      e = exp_err_a(wr, addr, pr);
      apb_xfer(0, wr, 12'(addr), wd, st, pr, 0, rd, err, cyc, lk);
      n_chk++; if (err !== e || cyc !== (wr ? 3 : 2) || lk) begin n_fail++; $display("FAIL rnd%0d addr=%h wr=%b got err=%b cyc=%0d leak=%b want err=%b", t, addr, wr, err, cyc, lk, e); end
      if (!wr) begin
        n_chk++; if (rd !== (e ? 32'h0 : mA[addr/4])) begin n_fail++; $display("FAIL rnd_rd%0d addr=%h got %h want %h", t, addr, rd, e ? 32'h0 : mA[addr/4]); end
      end else if (!e) begin
        for (int b = 0; b < 4; b++) if (st[b]) mA[addr/4][b*8 +: 8] = wd[b*8 +: 8];
      end
    end
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (a_regq[i*32 +: 32] !== mA[i]) begin n_fail++; $display("FAIL rnd_regq%0d got %h want %h", i, a_regq[i*32 +: 32], mA[i]); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int cyc; bit lk;
    n_chk++; if (a_perr !== 1'b0) begin n_fail++; $display("FAIL pre_abort proto got %b want 0", a_perr); end
    @(posedge pclk); #1;
    psel_a = 1; penable = 0; pwrite = 1; paddr = 12'h01C; pwdata = ~mA[7]; pstrb = 4'hF; pprot = 3'b000;
    @(posedge pclk); #1; psel_a = 0; penable = 1;
    @(negedge pclk);
    n_chk++; if (a_pready !== 1'b0) begin n_fail++; $display("FAIL abort_pready got %b want 0", a_pready); end
    @(posedge pclk); #1; penable = 0;
    repeat (2) @(posedge pclk); #1;
    n_chk++; if (a_perr !== 1'b1 || a_regq[7*32 +: 32] !== mA[7]) begin n_fail++; $display("FAIL abort got proto=%b reg=%h want 1/%h", a_perr, a_regq[7*32 +: 32], mA[7]); end
    apb_xfer(0, 1, 12'h030, 32'h0BADF00D, 4'hF, 3'b001, 0, rd, err, cyc, lk);
    mA[12] = 32'h0BADF00D;
    n_chk++; if (a_perr !== 1'b1 || err !== 1'b0 || a_regq[12*32 +: 32] !== 32'h0BADF00D) begin n_fail++; $display("FAIL abort_sticky got proto=%b err=%b reg=%h", a_perr, err, a_regq[12*32 +: 32]); end
  endtask

  task automatic test_reset_midwait();
    logic [31:0] rd; logic err; int cyc; bit lk;
    @(posedge pclk); #1;
    psel_b = 1; penable = 0; pwrite = 1; paddr = 12'h000; pwdata = 32'hA5A5A5A5; pstrb = 4'hF; pprot = 3'b000;
    @(posedge pclk); #1; penable = 1;
    #1 presetn = 0;
    #1;
    n_chk++; if ({b_pready, b_pslverr, a_pready, a_pslverr} !== 4'b0 || b_prdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_out got %b prdata=%h want 0", {b_pready, b_pslverr, a_pready, a_pslverr}, b_prdata); end
    n_chk++; if (b_regq !== '0 || a_regq !== '0 || {a_perr, b_perr} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_state regs or proto_err not cleared proto=%b", {a_perr, b_perr}); end
    repeat (2) @(posedge pclk); #1;
    psel_b = 0; penable = 0;
    #2 presetn = 1;
    for (int i = 0; i < 16; i++) mA[i] = '0;
    for (int i = 0; i < 12; i++) mB[i] = '0;
    n_chk++; if (b_regq[31:0] !== 32'h0) begin n_fail++; $display("FAIL rst_mid_reg0 got %h want 0", b_regq[31:0]); end
    apb_xfer(1, 1, 12'h000, 32'h600DCAFE, 4'hF, 3'b000, 0, rd, err, cyc, lk);
    n_chk++; if (cyc !== 5 || err !== 1'b0) begin n_fail++; $display("FAIL post_rst_wr got cyc=%0d err=%b want 5/0", cyc, err); end
    apb_xfer(1, 0, 12'h000, 32'h0, 4'h0, 3'b000, 0, rd, err, cyc, lk);
    n_chk++; if (rd !== 32'h600DCAFE || cyc !== 4) begin n_fail++; $display("FAIL post_rst_rd got %h cyc=%0d want 600dcafe/4", rd, cyc); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_errors();
    test_hw_conflict();
    test_random();
    test_abort();
    test_reset_midwait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
